trace_collector: RTL and testbench

- Sits directly downstream of trace_filter. Consumes each traced instruction plus trace_filter's drop_instr decision.
- Buffers every kept (non-dropped) instruction in a FIFO, tagged with its PC and the number of instructions dropped since the previous kept one.
- Presents the buffered entries on a valid/ready stream to the monitoring back-end.
- Accounts for every entry lost to FIFO overflow.

---
 rtl/trace_collector.sv | 117 +++++++++++
 tb/tb_trace_collector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_collector.sv
// trace_collector
//   Buffers every instruction kept by trace_filter in a first-word-fall-through
//   FIFO. Each entry holds the PC, the instruction word and the number of
//   instructions dropped since the previous kept one. Entries leave through a
//   valid/ready stream. Entries lost to overflow are counted.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   en                        collection enable (draining continues when 0)
//   pc, instr, pc_valid       retired instruction from the trace source
//   drop_instr                trace_filter verdict, 1 = discard
//   out_pc, out_instr,
//   out_skipped, out_valid    head entry of the FIFO
//   out_ready                 consumer accepts head when out_valid & out_ready
//   fill_level                number of stored entries (0..DEPTH)
//   overflow                  sticky, set on the first lost entry
//   lost_count                entries lost to overflow, saturating
module trace_collector #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic                     pc_valid,
  input  logic                     drop_instr,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [CNT_W-1:0]         out_skipped,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [15:0]              lost_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [CNT_W-1:0] mem_skip  [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] skip_cnt;

  logic keep;
  logic skip;
  logic full;
  logic pop;
  logic push;
  logic lost;

  assign keep = en & pc_valid & ~drop_instr;
  assign skip = en & pc_valid & drop_instr;
  assign full = (count == FULL_LEVEL);
  // count is a register, so out_valid never depends combinationally on the inputs.
  assign pop  = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a keep on a full FIFO still lands.
  assign push = keep & (~full | pop);
  assign lost = keep & full & ~pop;

  assign out_valid   = (count != '0);
  assign fill_level  = count;
  // Gated by out_valid so the outputs read zero while empty, including after reset.
  assign out_pc      = out_valid ? mem_pc[rd_ptr]    : '0;
  assign out_instr   = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_skipped = out_valid ? mem_skip[rd_ptr]  : '0;

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= instr;
      mem_skip[wr_ptr]  <= skip_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // A lost keep is accounted as one more skipped instruction for the next entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt <= '0;
    end else if (push) begin
      skip_cnt <= '0;
    end else if ((skip || lost) && (skip_cnt != '1)) begin
      skip_cnt <= skip_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      lost_count <= '0;
    end else if (lost) begin
      overflow <= 1'b1;
      if (lost_count != 16'hFFFF) lost_count <= lost_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_trace_collector.sv
module tb_trace_collector;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int SKMAX = (1 << CNT_W) - 1;

  logic             clk = 0;
  logic             rst;
  logic             en;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             pc_valid;
  logic             drop_instr;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] out_skipped;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       fill_level;
  logic             overflow;
  logic [15:0]      lost_count;

  trace_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .instr(instr),
    .pc_valid(pc_valid), .drop_instr(drop_instr),
    .out_pc(out_pc), .out_instr(out_instr), .out_skipped(out_skipped),
    .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .overflow(overflow), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          sk;
  } entry_t;

  // Reference model: the queue is the FIFO content, plus running counters.
  entry_t sb[$];
  int     skip_m;
  int     lost_m;
  bit     ovf_m;
  bit     popped;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    skip_m = 0;
    lost_m = 0;
    ovf_m  = 0;
    popped = 0;
  endtask

  // Model step on each active edge; inputs were driven 1 time unit after the previous edge.
  always @(posedge clk) begin
    if (!rst) begin
      int  occ;
      bit  k, s;
      entry_t e;
      k   = en && pc_valid && !drop_instr;
      s   = en && pc_valid && drop_instr;
      occ = sb.size() + (popped ? 1 : 0);
      if (k && (occ < DEPTH || popped)) begin
        e.pc = pc; e.instr = instr; e.sk = skip_m;
        sb.push_back(e);
        skip_m = 0;
      end else if (k) begin
        ovf_m = 1;
        if (lost_m < 16'hFFFF) lost_m++;
        if (skip_m < SKMAX) skip_m++;
      end else if (s) begin
        if (skip_m < SKMAX) skip_m++;
      end
      popped = 0;
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
      check("fill_level", {27'b0, fill_level}, sb.size());
      check("overflow", {31'b0, overflow}, {31'b0, ovf_m});
      check("lost_count", {16'b0, lost_count}, lost_m);
      if (out_valid && sb.size() != 0) begin
        check("out_pc", out_pc, sb[0].pc);
        check("out_instr", out_instr, sb[0].instr);
        check("out_skipped", {28'b0, out_skipped}, sb[0].sk);
        if (out_ready) begin
          void'(sb.pop_front());
          popped = 1;
        end
      end
    end
  end

  task automatic cyc(input bit e, input bit v, input bit d,
                     input logic [31:0] p, input logic [31:0] i);
    en = e; pc_valid = v; drop_instr = d; pc = p; instr = i;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (sb.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    idle(1);
    check("drain_done", {31'b0, sb.size() == 0}, 32'd1);
  endtask

  initial begin
    rst = 1; en = 0; pc = 0; instr = 0; pc_valid = 0; drop_instr = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Idle after reset
    @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_fill", {27'b0, fill_level}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_lost", {16'b0, lost_count}, 32'd0);
    @(posedge clk); #1;

    // Basic keep / skip
    out_ready = 1;
    cyc(1, 1, 0, 32'h100, 32'h0000006f);
    cyc(1, 1, 1, 32'h104, 32'h00130293);
    cyc(1, 1, 1, 32'h108, 32'h00130313);
    cyc(1, 1, 1, 32'h10C, 32'h00130393);
    cyc(1, 1, 0, 32'h110, 32'h00000067);
    drain();

    // Backpressure: 17 keeps into 16 slots
    out_ready = 0;
    for (int j = 0; j < 17; j++) cyc(1, 1, 0, 32'h2000 + 4 * j, 32'hA000_0000 + j);
    idle(1);
    @(negedge clk);
    check("bp_fill16", {27'b0, fill_level}, 32'd16);
    check("bp_ovf", {31'b0, overflow}, 32'd1);
    check("bp_lost1", {16'b0, lost_count}, 32'd1);
    @(posedge clk); #1;
    cyc(1, 1, 1, 32'h3000, 32'h1);
    cyc(1, 1, 1, 32'h3004, 32'h2);
    drain();
    cyc(1, 1, 0, 32'h3008, 32'h3);   // expects skipped = 1 lost + 2 drops
    drain();

    // Full with a concurrent pop
    out_ready = 0;
    for (int j = 0; j < 16; j++) cyc(1, 1, 0, 32'h4000 + 4 * j, 32'hB000_0000 + j);
    out_ready = 1;
    cyc(1, 1, 0, 32'h4100, 32'hB000_0100);
    out_ready = 0;
    idle(1);
    @(negedge clk);
    check("fp_fill16", {27'b0, fill_level}, 32'd16);
    check("fp_lost", {16'b0, lost_count}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Skip counter saturation and en gating
    for (int j = 0; j < 20; j++) cyc(1, 1, 1, 32'h5000 + 4 * j, 32'h13);
    cyc(1, 1, 0, 32'h5100, 32'h6f);
    cyc(1, 1, 1, 32'h5104, 32'h13);
    cyc(1, 1, 1, 32'h5108, 32'h13);
    cyc(1, 1, 1, 32'h510C, 32'h13);
    for (int j = 0; j < 5; j++) cyc(0, 1, 1, 32'h5200 + 4 * j, 32'h13);
    cyc(0, 1, 0, 32'h5300, 32'h99);  // en=0: not pushed
    cyc(1, 1, 0, 32'h5304, 32'h67);  // skipped = 3
    drain();

    // Randomized traffic
    for (int j = 0; j < 400; j++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
    end
    drain();

    // Asynchronous reset mid-operation
    out_ready = 0;
    for (int j = 0; j < 3; j++) cyc(1, 1, 1, 32'h6000 + 4 * j, 32'h13);
    for (int j = 0; j < 5; j++) cyc(1, 1, 0, 32'h6100 + 4 * j, 32'hC000_0000 + j);
    en = 0; pc_valid = 0;
    @(posedge clk); #3;
    rst = 1;
    model_reset();
    #1;
    check("mr_valid", {31'b0, out_valid}, 32'd0);
    check("mr_fill", {27'b0, fill_level}, 32'd0);
    check("mr_pc", out_pc, 32'd0);
    check("mr_lost", {16'b0, lost_count}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    cyc(1, 1, 0, 32'h7000, 32'h6f);  // skipped = 0 after reset
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
